// File: rtl/gerador_janelas.sv
// Multi-channel window generator driven by a shared period counter.
// Continuous or one-shot counting; each channel goes low inside (start, end).
module gerador_janelas #(
  parameter int WIDTH         = 9,
  parameter int CHANNELS      = 4,
  parameter int PERIODO_RESET = 499,
  parameter int INICIO_RESET  = 19,
  parameter int FIM_RESET     = 90
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  input  logic                        Enable,
  input  logic                        Modo,
  input  logic                        Start,
  input  logic [WIDTH-1:0]            Periodo,
  input  logic                        Wr,
  input  logic [$clog2(CHANNELS)-1:0] WrCanal,
  input  logic [WIDTH-1:0]            WrInicio,
  input  logic [WIDTH-1:0]            WrFim,
  output logic [WIDTH-1:0]            count,
  output logic [CHANNELS-1:0]         f,
  output logic                        Fim,
  output logic                        Ativo
);

  localparam int CW = $clog2(CHANNELS);

  logic [WIDTH-1:0] periodo_q;
  logic             modo_q;
  logic             run_q;
  logic [WIDTH-1:0] inicio_q [CHANNELS];
  logic [WIDTH-1:0] fim_q    [CHANNELS];
  logic             idle;
  logic             wrap;

  assign idle = modo_q && !run_q;
  assign wrap = !idle && (count == periodo_q);

  // Period and mode are only re-sampled at a wrap or while idle,
  // so a running period is never cut short.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count     <= '0;
      periodo_q <= WIDTH'(PERIODO_RESET);
      modo_q    <= 1'b0;
      run_q     <= 1'b0;
      Fim       <= 1'b0;
      Ativo     <= 1'b0;
    end else if (!Enable) begin
      Fim <= 1'b0;
    end else begin
      Fim <= 1'b0;
      unique case (1'b1)
        idle: begin
          periodo_q <= Periodo;
          modo_q    <= Modo;
          run_q     <= Modo && Start;
          Ativo     <= !Modo || Start;
        end
        wrap: begin
          count     <= '0;
          Fim       <= 1'b1;
          periodo_q <= Periodo;
          modo_q    <= Modo;
          run_q     <= 1'b0;
          Ativo     <= !Modo;
        end
        default: begin
          count <= count + WIDTH'(1);
          Ativo <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      f <= '1;
    end else if (Enable) begin
      for (int i = 0; i < CHANNELS; i++) begin
        f[i] <= !((count > inicio_q[i]) && (count < fim_q[i]));
      end
    end
  end

  // Out-of-range channel indices match no entry and are dropped.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        inicio_q[i] <= WIDTH'(INICIO_RESET);
        fim_q[i]    <= WIDTH'(FIM_RESET);
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (Wr && (WrCanal == CW'(i))) begin
          inicio_q[i] <= WrInicio;
          fim_q[i]    <= WrFim;
        end
      end
    end
  end

endmodule
